uart_rx_deframer: RTL and testbench
===================================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: maximum payload bytes per frame, 1..255.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: maximum idle clocks allowed between bytes inside a frame.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port vd_i  in  1  one-cycle strobe marking a received byte from the UART PHY.
REQ-006 SHALL have port data_i  in  8  received byte; valid only when vd_i=1.
REQ-007 SHALL have port m_data_o  out  8  payload byte output.
REQ-008 SHALL have port m_valid_o  out  1  payload byte available.
REQ-009 SHALL have port m_ready_i  in  1  consumer accepts the byte.
REQ-010 SHALL have port m_last_o  out  1  marks the final payload byte of a frame.
REQ-011 SHALL have port frame_err_o  out  1  one-cycle pulse when a frame is discarded.
REQ-012 SHALL have port err_code_o  out  2  error cause, held until the next error: 1=checksum, 2=length, 3=timeout.

Function
REQ-013 Frame format SHALL be: SOF byte 0xA5, then LEN, then LEN payload bytes, then CHK; CHK = XOR of LEN and all payload bytes.
REQ-014 The FSM SHALL have states IDLE, GET_LEN, GET_PAY, GET_CHK and OUT.
REQ-015 In IDLE, a byte equal to 0xA5 SHALL move the FSM to GET_LEN; any other byte SHALL be ignored silently.
REQ-016 In GET_LEN, LEN=0 or LEN>MAX_LEN SHALL discard the frame with err code 2 and return to IDLE.
REQ-017 In GET_LEN, a valid LEN SHALL be stored, seed the running XOR, and move the FSM to GET_PAY.
REQ-018 In GET_PAY, each byte SHALL be written to the buffer at an incrementing index starting at 0 and XORed into the checksum; after LEN bytes the FSM SHALL move to GET_CHK.
REQ-019 In GET_CHK, a match SHALL move the FSM to OUT; a mismatch SHALL discard the frame with err code 1 and return to IDLE.
REQ-020 In OUT, bytes SHALL be presented in order from index 0 using valid/ready: a transfer occurs when m_valid_o and m_ready_i are both 1.
REQ-021 While stalled, m_data_o and m_last_o SHALL remain stable.
REQ-022 m_last_o SHALL be 1 only on byte LEN-1; after that byte transfers, the FSM SHALL return to IDLE.
REQ-023 First m_valid_o SHALL assert no later than 2 cycles after the CHK strobe; back-to-back transfers SHALL sustain 1 byte per cycle.
REQ-024 Bytes arriving during OUT SHALL be dropped without error; a 0xA5 in OUT SHALL NOT start a frame.
REQ-025 In GET_LEN, GET_PAY or GET_CHK, TIMEOUT_CYC clocks without vd_i SHALL discard the frame with err code 3 and return to IDLE; the counter SHALL reset on each vd_i.
REQ-026 If vd_i and a timeout expiry fall on the same cycle, the byte SHALL win and no timeout SHALL occur.
REQ-027 A discarded frame SHALL cause exactly one frame_err_o pulse and SHALL produce no m_valid_o.
REQ-028 Index and length counters SHALL be 8 bits and SHALL NOT wrap within a legal frame.

Reset
REQ-029 On rst_i, the FSM SHALL enter IDLE, and m_valid_o, m_last_o and frame_err_o SHALL be 0.
REQ-030 On rst_i, err_code_o, m_data_o, all counters and the XOR register SHALL be 0; buffer contents need not be cleared.
REQ-031 Reset asserted mid-frame or mid-OUT SHALL abandon the frame without an error pulse.

Structure
REQ-032 A shared package uart_pkg SHALL hold the SOF constant 0xA5, the FSM state encoding and the err code constants.
REQ-033 The payload store SHALL be one sub-module, uart_frame_buf: MAX_LEN x 8, one write port, one registered read port.

Verification
REQ-034 Feed A5 03 11 22 33 03 with m_ready_i=1 -> outputs 11, 22, 33 on consecutive cycles, m_last_o only on 33, no frame_err_o.
REQ-035 Feed A5 02 10 20 31 -> frame_err_o pulses once, err_code_o=1, no m_valid_o.
REQ-036 Feed A5 00, then A5 11 with MAX_LEN=16 -> two frame_err_o pulses, err_code_o=2 each time, FSM back in IDLE.
REQ-037 Feed A5 04 01, then no byte for TIMEOUT_CYC cycles -> frame_err_o pulses, err_code_o=3; a following good frame is delivered intact.
REQ-038 Good 3-byte frame with m_ready_i held 0 for 10 cycles mid-output, and an extra A5 byte injected during OUT -> no data loss or reorder, outputs stable while stalled, injected byte dropped.
REQ-039 Assert rst_i during GET_PAY -> all outputs 0 in the same cycle, no error pulse; the next good frame is delivered correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive deframer: start-of-frame marker,
// FSM state encoding, error codes and a length-legality helper.
package uart_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_LEN = 3'd1,
    ST_GET_PAY = 3'd2,
    ST_GET_CHK = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // A length byte is legal when it is non-zero and fits the payload store.
  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8, one write port, one registered read port.
// Ports:
//   clk_i, rst_i        clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr       read request; rd_data updates on the next rising edge
//   rd_data             registered read data, holds when rd_en=0
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // Storage array is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data <= 8'd0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// Receives SOF/LEN/payload/CHK frames from a byte-strobe UART PHY, verifies
// length and XOR checksum, and replays the payload on a valid/ready stream.
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   vd_i, data_i              received byte strobe and value
//   m_data_o, m_valid_o, m_ready_i, m_last_o   payload stream
//   frame_err_o               one-cycle pulse per discarded frame
//   err_code_o                cause of the last discard (1=chk, 2=len, 3=timeout)
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vd_i,
  input  logic [7:0] data_i,
  output logic [7:0] m_data_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       m_last_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic [7:0]    len_q, wr_idx_q, rd_idx_q, xor_q;
  logic [TW-1:0] tmo_q;

  logic          in_frame_c, timeout_c, xfer_c;
  logic          rd_en_c, wr_en_c, err_pulse_c, valid_d, last_d;
  logic [7:0]    rd_sel_c, nxt_rd_c;
  logic [1:0]    err_code_c;

  assign in_frame_c = (state_q == ST_GET_LEN) || (state_q == ST_GET_PAY) ||
                      (state_q == ST_GET_CHK);
  // A byte on the expiry cycle wins over the timeout.
  assign timeout_c  = in_frame_c && !vd_i && (tmo_q == TMO_LAST);
  assign xfer_c     = m_valid_o && m_ready_i;
  assign wr_en_c    = (state_q == ST_GET_PAY) && vd_i;
  assign nxt_rd_c   = rd_idx_q + 8'd1;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (vd_i && data_i == SOF) state_d = ST_GET_LEN;
      ST_GET_LEN: if (vd_i) state_d = len_ok(data_i, MAX_LEN) ? ST_GET_PAY : ST_IDLE;
                  else if (timeout_c) state_d = ST_IDLE;
      ST_GET_PAY: if (vd_i) begin
                    if (wr_idx_q == len_q - 8'd1) state_d = ST_GET_CHK;
                  end else if (timeout_c) state_d = ST_IDLE;
      ST_GET_CHK: if (vd_i) state_d = (data_i == xor_q) ? ST_OUT : ST_IDLE;
                  else if (timeout_c) state_d = ST_IDLE;
      ST_OUT:     if (xfer_c && m_last_o) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output/control logic: error reporting and read-port sequencing.
  always_comb begin
    err_pulse_c = 1'b0;
    err_code_c  = err_code_o;
    rd_en_c     = 1'b0;
    rd_sel_c    = 8'd0;
    valid_d     = m_valid_o;
    last_d      = m_last_o;
    case (state_q)
      ST_GET_LEN: begin
        if (vd_i && !len_ok(data_i, MAX_LEN)) begin
          err_pulse_c = 1'b1;
          err_code_c  = ERR_LEN;
        end else if (timeout_c) begin
          err_pulse_c = 1'b1;
          err_code_c  = ERR_TMO;
        end
      end
      ST_GET_PAY: begin
        if (timeout_c) begin
          err_pulse_c = 1'b1;
          err_code_c  = ERR_TMO;
        end
      end
      ST_GET_CHK: begin
        if (vd_i && data_i == xor_q) begin
          // Prefetch byte 0 so valid rises one cycle after the CHK strobe.
          rd_en_c  = 1'b1;
          rd_sel_c = 8'd0;
          valid_d  = 1'b1;
          last_d   = (len_q == 8'd1);
        end else if (vd_i) begin
          err_pulse_c = 1'b1;
          err_code_c  = ERR_CHK;
        end else if (timeout_c) begin
          err_pulse_c = 1'b1;
          err_code_c  = ERR_TMO;
        end
      end
      ST_OUT: begin
        if (xfer_c) begin
          if (m_last_o) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            rd_en_c  = 1'b1;
            rd_sel_c = nxt_rd_c;
            last_d   = (nxt_rd_c == len_q - 8'd1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: counters, checksum and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q       <= 8'd0;
      wr_idx_q    <= 8'd0;
      rd_idx_q    <= 8'd0;
      xor_q       <= 8'd0;
      tmo_q       <= '0;
      m_valid_o   <= 1'b0;
      m_last_o    <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else begin
      if (in_frame_c && !vd_i) tmo_q <= tmo_q + TW'(1);
      else                     tmo_q <= '0;
      if (state_q == ST_GET_LEN && vd_i && len_ok(data_i, MAX_LEN)) begin
        len_q    <= data_i;
        xor_q    <= data_i;
        wr_idx_q <= 8'd0;
      end
      if (wr_en_c) begin
        xor_q    <= xor_q ^ data_i;
        wr_idx_q <= wr_idx_q + 8'd1;
      end
      if (rd_en_c) rd_idx_q <= rd_sel_c;
      m_valid_o   <= valid_d;
      m_last_o    <= last_d;
      frame_err_o <= err_pulse_c;
      if (err_pulse_c) err_code_o <= err_code_c;
    end
  end

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (wr_en_c),
    .wr_addr(AW'(wr_idx_q)),
    .wr_data(data_i),
    .rd_en  (rd_en_c),
    .rd_addr(AW'(rd_sel_c)),
    .rd_data(m_data_o)
  );

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: a frame-level reference model pushes
// expected payload bytes / error codes; a negedge monitor pops and compares.
module tb_uart_rx_deframer;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vd = 1'b0;
  logic [7:0] data = 8'd0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic       m_last;
  logic       frame_err;
  logic [1:0] err_code;

  logic [7:0] exp_data [$];
  logic       exp_last [$];
  logic [1:0] exp_err  [$];
  logic [1:0] last_err = 2'd0;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] mon_d;
  logic       mon_l;
  logic [1:0] mon_e;

  uart_rx_deframer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .vd_i(vd), .data_i(data),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_last_o(m_last), .frame_err_o(frame_err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Consumer ready: 0=always ready, 1=random, 2=stalled.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom % 3) != 0;
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: stability while stalled, payload ordering, error codes.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        chk(m_valid == 1'b1, "stall_valid", int'(m_valid), 1);
        chk(m_data == prev_data, "stall_data", int'(m_data), int'(prev_data));
        chk(m_last == prev_last, "stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid) begin
        if (exp_data.size() == 0) begin
          chk(1'b0, "spurious_valid", int'(m_data), 0);
        end else if (m_ready) begin
          mon_d = exp_data.pop_front();
          mon_l = exp_last.pop_front();
          chk(m_data == mon_d, "data", int'(m_data), int'(mon_d));
          chk(m_last == mon_l, "last", int'(m_last), int'(mon_l));
        end
      end
      if (frame_err) begin
        if (exp_err.size() == 0) begin
          chk(1'b0, "spurious_err", int'(err_code), 0);
        end else begin
          mon_e = exp_err.pop_front();
          chk(err_code == mon_e, "err_code", int'(err_code), int'(mon_e));
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Reference model: decide the outcome of a whole frame from its bytes.
  task automatic model_frame(input bq_t f);
    int len;
    logic [7:0] acc;
    len = int'(f[1]);
    if (len == 0 || len > MAX_LEN) begin
      exp_err.push_back(2'd2);
      last_err = 2'd2;
    end else begin
      acc = f[1];
      for (int i = 0; i < len; i++) acc = acc ^ f[2 + i];
      if (acc == f[len + 2]) begin
        for (int i = 0; i < len; i++) begin
          exp_data.push_back(f[2 + i]);
          exp_last.push_back(i == len - 1);
        end
      end else begin
        exp_err.push_back(2'd1);
        last_err = 2'd1;
      end
    end
  endtask

  function automatic bq_t make_frame(input int len, input bit corrupt);
    bq_t f;
    logic [7:0] x, b;
    f.push_back(8'hA5);
    f.push_back(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
    if (corrupt) x = x ^ 8'($urandom_range(255, 1));
    f.push_back(x);
    return f;
  endfunction

  // Entered and left at 1 time unit after a rising edge; idle = clean cycles after.
  task automatic send_byte(input logic [7:0] b, input int idle);
    vd = 1'b1;
    data = b;
    @(posedge clk); #1;
    vd = 1'b0;
    data = 8'($urandom);
    for (int i = 0; i < idle; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bq_t f, input int gmin, input int gmax);
    model_frame(f);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], $urandom_range(gmax, gmin));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data.size() != 0 || exp_err.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 400, "drain_timeout", exp_data.size() + exp_err.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk(m_valid == 1'b0, {tag, "_valid"}, int'(m_valid), 0);
    chk(m_last == 1'b0, {tag, "_last"}, int'(m_last), 0);
    chk(frame_err == 1'b0, {tag, "_ferr"}, int'(frame_err), 0);
    chk(err_code == 2'd0, {tag, "_code"}, int'(err_code), 0);
    chk(m_data == 8'd0, {tag, "_data"}, int'(m_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int k;
    logic [7:0] g;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic good frame, always ready: latency and back-to-back throughput
    ready_mode = 0;
    f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_frame(f, 0, 0);
    k = 0;
    while (!m_valid && k < 3) begin @(posedge clk); #1; k++; end
    chk(m_valid == 1'b1 && k <= 2, "first_valid_latency", k, 2);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      chk(m_valid == 1'b1, "b2b_valid", int'(m_valid), 1);
    end
    @(posedge clk); #1;
    chk(m_valid == 1'b0, "valid_after_last", int'(m_valid), 0);
    wait_drain();
    chk(frame_err == 1'b0 && err_code == 2'd0, "no_err_good", int'(err_code), 0);

    // Checksum error
    f = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    send_frame(f, 0, 1);
    wait_drain();
    chk(err_code == 2'd1, "chk_err_held", int'(err_code), 1);

    // Length errors: zero and MAX_LEN+1
    f = '{8'hA5, 8'h00};
    send_frame(f, 0, 0);
    f = '{8'hA5, 8'h11};
    send_frame(f, 0, 0);
    wait_drain();
    chk(err_code == 2'd2, "len_err_held", int'(err_code), 2);

    // Largest legal frame and single-byte frame
    send_frame(make_frame(MAX_LEN, 1'b0), 0, 2);
    wait_drain();
    send_frame(make_frame(1, 1'b0), 0, 2);
    wait_drain();

    // Timeout: exact expiry boundary
    exp_err.push_back(2'd3);
    last_err = 2'd3;
    send_byte(8'hA5, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, TMO - 1);
    chk(frame_err == 1'b0, "tmo_not_early", int'(frame_err), 0);
    @(posedge clk); #1;
    chk(frame_err == 1'b1, "tmo_fires", int'(frame_err), 1);
    wait_drain();
    chk(err_code == 2'd3, "tmo_code", int'(err_code), 3);
    send_frame(make_frame(4, 1'b0), 0, 2);
    wait_drain();

    // Byte on the expiry cycle wins: gaps of TMO-1 idle clocks
    send_frame(make_frame(2, 1'b0), TMO - 1, TMO - 1);
    wait_drain();

    // Stall through output with a stray SOF injected during OUT
    ready_mode = 2;
    send_frame(make_frame(3, 1'b0), 0, 0);
    k = 0;
    while (!m_valid && k < 5) begin @(posedge clk); #1; k++; end
    chk(m_valid == 1'b1, "stall_valid_seen", int'(m_valid), 1);
    send_byte(8'hA5, 0);
    repeat (9) begin @(posedge clk); #1; end
    ready_mode = 0;
    wait_drain();
    send_frame(make_frame(5, 1'b0), 0, 1);
    wait_drain();

    // Reset during payload reception
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    last_err = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(make_frame(6, 1'b0), 0, 1);
    wait_drain();

    // Randomized frames with random backpressure and inter-frame noise
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if (($urandom % 3) == 0) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, $urandom_range(2, 0));
      end
      case ($urandom % 4)
        0, 1: send_frame(make_frame($urandom_range(MAX_LEN, 1), 1'b0), 0, 3);
        2:    send_frame(make_frame($urandom_range(MAX_LEN, 1), 1'b1), 0, 3);
        default: begin
          f = {};
          f.push_back(8'hA5);
          f.push_back((($urandom % 2) == 0) ? 8'h00 : 8'($urandom_range(255, MAX_LEN + 1)));
          send_frame(f, 0, 3);
        end
      endcase
      wait_drain();
    end
    chk(err_code == last_err, "err_code_hold", int'(err_code), int'(last_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
